// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around mem_arbiter.
// The arbiter uses the master view; requesters and the memory sit on the slave view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_done;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency single-port memory between fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise data always beats fetch.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          pick_d, pick_i;

    logic          i_gnt_q, i_gnt_d;
    logic          i_done_q, i_done_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          d_gnt_q, d_gnt_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;

`ifdef MEM_ARB_RR_EN
    // last_q = 1 when data was granted most recently; a tie goes to the other port.
    logic last_q, last_d;

    assign pick_d = bus.d_req && (!bus.i_req || !last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (bus.d_req || bus.i_req)) begin
            last_d = pick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_d = bus.d_req;
`endif

    assign pick_i = bus.i_req && !pick_d;

    // State and every registered output.
    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_gnt_q   <= 1'b0;
            i_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_gnt_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_rdata_q <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            i_gnt_q   <= i_gnt_d;
            i_done_q  <= i_done_d;
            i_rdata_q <= i_rdata_d;
            d_gnt_q   <= d_gnt_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Next-state logic.
    // NOTE: a default before the case gives every path a value, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = BUSY_D;
                end else if (pick_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; gnt/done default low so they only pulse.
    always_comb begin
        i_gnt_d   = 1'b0;
        i_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_gnt_d   = 1'b0;
        d_done_d  = 1'b0;
        d_rdata_d = d_rdata_q;
        m_en_d    = m_en_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    d_gnt_d   = 1'b1;
                    m_en_d    = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else if (pick_i) begin
                    i_gnt_d  = 1'b1;
                    m_en_d   = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = bus.i_addr;
                end
            end
            BUSY_I: begin
                if (bus.m_ready) begin
                    i_done_d  = 1'b1;
                    i_rdata_d = bus.m_rdata;
                    m_en_d    = 1'b0;
                    m_we_d    = 1'b0;
                end
            end
            BUSY_D: begin
                if (bus.m_ready) begin
                    d_done_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                    m_en_d = 1'b0;
                    m_we_d = 1'b0;
                end
            end
            default: begin
                m_en_d = 1'b0;
                m_we_d = 1'b0;
            end
        endcase
    end

    assign bus.i_gnt   = i_gnt_q;
    assign bus.i_done  = i_done_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_gnt   = d_gnt_q;
    assign bus.d_done  = d_done_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model with programmable latency plus
// per-port read-data scoreboards; grant order is logged and compared per build.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] i_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    bit            gnt_log[$];
    logic [DW-1:0] mem [bit [AW-1:0]];
    int            mem_k = 1;
    int            wait_cnt = 0;
    logic [DW-1:0] d_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return addr ^ 32'hA5A5_0000;
    endfunction

    // Memory: m_ready is presented for the k-th edge after m_en rose.
    always @(negedge clk) begin
        if (bus.m_en) begin
            wait_cnt     = wait_cnt + 1;
            bus.m_ready  = (wait_cnt == mem_k);
            bus.m_rdata  = bus.m_ready ? mem_read(bus.m_addr) : 32'hDEAD_BEEF;
            if (bus.m_ready && bus.m_we) mem[bus.m_addr] = bus.m_wdata;
        end else begin
            wait_cnt    = 0;
            bus.m_ready = 1'b0;
        end
    end

    // Scoreboard: every done pulse pops the expected data for that port.
    always @(negedge clk) begin
        if (bus.d_gnt) gnt_log.push_back(1'b1);
        if (bus.i_gnt) gnt_log.push_back(1'b0);
        if (bus.i_done) begin
            if (i_exp_q.size() == 0) check("i_done_unexpected", 1, 0);
            else check("i_rdata", bus.i_rdata, i_exp_q.pop_front());
        end
        if (bus.d_done) begin
            if (d_exp_q.size() == 0) check("d_done_unexpected", 1, 0);
            else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input int budget, output int cycles);
        cycles = 0;
        while (!(is_d ? bus.d_done : bus.i_done) && cycles < budget) begin
            step(1);
            cycles++;
        end
        check(is_d ? "d_done_timeout" : "i_done_timeout", is_d ? bus.d_done : bus.i_done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        i_exp_q.delete();
        d_exp_q.delete();
        d_last = '0;
        reset = 1'b1;
    endtask

    initial begin
        int  cyc;
        int  dones;
        bit  exp_g[4];

        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        d_last      = '0;
        mem[32'h40] = 32'h2002_000A;

        // Reset values
        step(3);
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_i_done", bus.i_done, 0);
        check("rst_d_done", bus.d_done, 0);
        check("rst_m_en", bus.m_en, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        reset = 1'b1;
        step(1);
        check("idle_m_en", bus.m_en, 0);

        // Single fetch, k=1
        mem_k = 1;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        i_exp_q.push_back(32'h2002_000A);
        step(1);
        check("fetch_gnt", bus.i_gnt, 1);
        check("fetch_m_en", bus.m_en, 1);
        check("fetch_m_addr", bus.m_addr, 32'h40);
        check("fetch_m_we", bus.m_we, 0);
        check("fetch_early_done", bus.i_done, 0);
        step(1);
        check("fetch_done", bus.i_done, 1);
        check("fetch_gnt_pulse", bus.i_gnt, 0);
        check("fetch_m_en_drop", bus.m_en, 0);
        check("fetch_i_rdata", bus.i_rdata, 32'h2002_000A);
        bus.i_req = 1'b0;
        step(1);
        check("fetch_done_pulse", bus.i_done, 0);
        check("fetch_idle_m_en", bus.m_en, 0);

        // Store, k=3: d_rdata must stay unchanged
        mem_k = 3;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h54;
        bus.d_wdata = 32'd7;
        d_exp_q.push_back(d_last);
        step(1);
        check("store_gnt", bus.d_gnt, 1);
        check("store_m_en", bus.m_en, 1);
        check("store_m_we", bus.m_we, 1);
        check("store_m_addr", bus.m_addr, 32'h54);
        check("store_m_wdata", bus.m_wdata, 32'd7);
        for (int c = 0; c < 2; c++) begin
            step(1);
            check("store_hold_m_en", bus.m_en, 1);
            check("store_hold_m_we", bus.m_we, 1);
            check("store_hold_m_wdata", bus.m_wdata, 32'd7);
            check("store_no_done", bus.d_done, 0);
            check("store_gnt_pulse", bus.d_gnt, 0);
        end
        step(1);
        check("store_done", bus.d_done, 1);
        check("store_m_en_drop", bus.m_en, 0);
        check("store_m_we_drop", bus.m_we, 0);
        check("store_d_rdata_kept", bus.d_rdata, d_last);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step(1);

        // Load the stored word back, k=2
        mem_k = 2;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h54;
        d_last = 32'd7;
        d_exp_q.push_back(32'd7);
        wait_done(1'b1, 20, cyc);
        check("load_latency", cyc, 3);
        bus.d_req = 1'b0;
        step(1);

        // Contention for 4 transactions, k=1, from a fresh reset
        do_reset();
        mem_k = 1;
        gnt_log.delete();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h200;
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int t = 0; t < 4; t++) begin
            if (exp_g[t]) d_exp_q.push_back(32'hA5A5_0200);
            else          i_exp_q.push_back(32'hA5A5_0100);
        end
        dones = 0;
        cyc   = 0;
        while (dones < 4 && cyc < 40) begin
            step(1);
            cyc++;
            if (bus.i_done || bus.d_done) dones++;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("contention_dones", dones, 4);
        check("contention_cycles", cyc, 8);
        step(2);
        check("contention_grant_count", gnt_log.size(), 4);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("contention_grant_%0d", t), gnt_log[t], exp_g[t]);
        end
        i_exp_q.delete();

        // Back-to-back fetches, address changed in each done cycle
        mem_k = 1;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        i_exp_q.push_back(32'hA5A5_0300);
        step(1);
        check("b2b_gnt_0", bus.i_gnt, 1);
        check("b2b_addr_0", bus.m_addr, 32'h300);
        for (int t = 1; t < 3; t++) begin
            step(1);
            check("b2b_done", bus.i_done, 1);
            bus.i_addr = 32'h300 + 32'(4 * t);
            i_exp_q.push_back((32'h300 + 32'(4 * t)) ^ 32'hA5A5_0000);
            step(1);
            check("b2b_regrant", bus.i_gnt, 1);
            check("b2b_done_gap", bus.i_done, 0);
            check("b2b_next_addr", bus.m_addr, 32'h300 + 32'(4 * t));
        end
        step(1);
        check("b2b_done_last", bus.i_done, 1);
        bus.i_req = 1'b0;
        step(1);
        check("b2b_idle_m_en", bus.m_en, 0);

        // Reset in BUSY_D with m_ready low; fetch stays pending
        mem_k = 5;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h400;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        step(1);
        check("abort_d_gnt", bus.d_gnt, 1);
        check("abort_m_en", bus.m_en, 1);
        step(1);
        check("abort_busy_m_en", bus.m_en, 1);
        check("abort_busy_no_done", bus.d_done, 0);
        reset = 1'b0;
        bus.d_req = 1'b0;
        step(1);
        check("abort_m_en_drop", bus.m_en, 0);
        check("abort_no_d_done", bus.d_done, 0);
        check("abort_no_i_gnt", bus.i_gnt, 0);
        reset = 1'b1;
        mem_k = 1;
        i_exp_q.push_back(32'hA5A5_0500);
        step(1);
        check("after_abort_i_gnt", bus.i_gnt, 1);
        check("after_abort_m_addr", bus.m_addr, 32'h500);
        check("after_abort_m_en", bus.m_en, 1);
        step(1);
        check("after_abort_i_done", bus.i_done, 1);
        bus.i_req = 1'b0;
        step(3);
        check("after_abort_d_done", bus.d_done, 0);

        check("i_queue_empty", i_exp_q.size(), 0);
        check("d_queue_empty", d_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the single-cycle MIPS core: lets instruction fetch and data load/store share one unified single-port memory with variable latency. Sits between `mips` and a unified memory that replaces the separate `imem`/`dmem` pair. Requesters are stalled by holding `*_req` until `*_done`. All outputs are registered.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low; `0` at a rising edge resets the block.
- `i_req`  input  1  fetch request; held with stable `i_addr` until `i_done`.
- `i_addr`  input  AW  fetch byte address.
- `i_gnt`  output  1  one-cycle pulse when the fetch request is accepted.
- `i_done`  output  1  one-cycle pulse when fetch data is valid.
- `i_rdata`  output  DW  fetch data; valid when `i_done=1`, held until the next fetch completes.
- `d_req`  input  1  data request; held with stable `d_we`/`d_addr`/`d_wdata` until `d_done`.
- `d_we`  input  1  `1` = write, `0` = read.
- `d_addr`  input  AW  data byte address.
- `d_wdata`  input  DW  store data.
- `d_gnt`  output  1  one-cycle accept pulse.
- `d_done`  output  1  one-cycle completion pulse, for reads and writes.
- `d_rdata`  output  DW  load data; valid when `d_done=1` after a read. Unchanged by writes.
- `m_en`  output  1  memory access strobe; held high until `m_ready` is sampled high.
- `m_we`  output  1  memory write enable.
- `m_addr`  output  AW  memory address, latched from the winning requester.
- `m_wdata`  output  DW  memory write data, latched.
- `m_rdata`  input  DW  memory read data; valid when `m_ready=1`.
- `m_ready`  input  1  memory completion; only meaningful while `m_en=1`.

## Operation
- FSM states: `IDLE`, `BUSY_I`, `BUSY_D`.
- `IDLE`:
  - At a clock edge, if any `*_req` is high, select a winner and move to `BUSY_I` or `BUSY_D`.
  - On that edge, set `m_en=1` and set `m_we` (`d_we` for data, `0` for fetch).
  - On that edge, latch `m_addr`/`m_wdata` and pulse the winner's `*_gnt` for the following cycle.
- `BUSY_x`:
  - Outputs are held stable.
  - On an edge with `m_ready=1`: clear `m_en`/`m_we`, register `m_rdata` into `x_rdata` (reads only), pulse `x_done` for the following cycle, return to `IDLE`.
- Arbitration (default, fixed priority): data beats fetch when both requests are high in `IDLE`.
- A request still high in the `x_done` cycle counts as a new request. This allows back-to-back transactions; the requester must drop `*_req` in the `done` cycle if it has no further access.
- The losing requester simply stays pending; it is never dropped.
- Input changes while `BUSY` have no effect on `m_*`.

## Timing
- Reset values: state `IDLE`; all `*_gnt`, `*_done`, `m_en`, `m_we` = 0; `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
- Latency, with the request sampled at edge E0 and `m_ready` sampled high at edge E0+k (k ≥ 1):
  - `*_gnt` and `m_en` are high in cycle E0..E0+1.
  - `*_done` is high in cycle E0+k..E0+k+1.
  - Minimum request-to-done is 2 cycles.
  - Throughput is one transaction per k+1 cycles.
- `m_ready` sampled in the same edge as the grant decision is ignored, because `m_en` was 0.
- `reset=0` mid-transaction: return to `IDLE` on that edge and drop `m_en` immediately. No `done` is issued; the in-flight access is abandoned. The memory must tolerate `m_en` falling before `m_ready`.
- Simultaneous `i_req` and `d_req` arriving while `BUSY`: both are evaluated at the first `IDLE` edge after completion.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin fairness. One register `last` records the most recently granted port (reset value: fetch).
  - When both requests are high in `IDLE`, grant the port not equal to `last`.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority; the `last` register is not built.

## Test plan
- Fetch only: `i_req=1`, `i_addr=0x40`, memory returns `m_rdata=0x2002000A` with k=1.
  - Required: `i_gnt` pulses one cycle, then `i_done=1` with `i_rdata=0x2002000A`.
  - Required: `m_en` is high for exactly 1 cycle with `m_addr=0x40`.
- Store: `d_req=1`, `d_we=1`, `d_addr=0x54`, `d_wdata=7`, k=3.
  - Required: `m_we=1`, `m_wdata=7` held 3 cycles.
  - Required: `d_done` pulses and `d_rdata` is unchanged.
- Contention, both requests held continuously for 4 transactions, k=1:
  - Without `MEM_ARB_RR_EN`: all 4 grants go to `d`.
  - With `MEM_ARB_RR_EN`: grants go d, i, d, i. `last` resets to fetch, so data wins the first tie.
- Back-to-back fetch, `i_req` held high, k=1:
  - Required: `i_done` asserts every 2 cycles; the `i_addr` changed in the `done` cycle appears on the next `m_addr`.
- Reset mid-access: `reset=0` while in `BUSY_D` with `m_ready=0`.
  - Required: next cycle `m_en=0` and no `d_done`.
  - Required: after release, a pending `i_req` is granted normally.
